// File: rtl/qspi_rd_master_if.sv
// Request/response and QSPI pin bundle for the qspi_rd_master read initiator.
interface qspi_rd_master_if;
  localparam int unsigned ADDR_W = 24;
  localparam int unsigned DATA_W = 32;

  // Host request / completion side
  logic              rd_req;
  logic              rd_fast;
  logic [ADDR_W-1:0] rd_addr;
  logic              rd_busy;
  logic              rd_valid;
  logic [DATA_W-1:0] rd_data;

  // QSPI pins (single-lane usage)
  logic              qspi_sck;
  logic              qspi_csn;
  logic              qspi_mosi;
  logic              qspi_miso;
  logic              qspi_wpn;
  logic              qspi_holdn;

  // Read initiator view
  modport master (
    input  rd_req, rd_fast, rd_addr, qspi_miso,
    output rd_busy, rd_valid, rd_data,
    output qspi_sck, qspi_csn, qspi_mosi, qspi_wpn, qspi_holdn
  );

  // Host plus flash responder view
  modport slave (
    output rd_req, rd_fast, rd_addr, qspi_miso,
    input  rd_busy, rd_valid, rd_data,
    input  qspi_sck, qspi_csn, qspi_mosi, qspi_wpn, qspi_holdn
  );
endinterface

// File: rtl/qspi_rd_master.sv
// QSPI single-lane Read (03h) / Fast Read (0Bh) initiator returning one 32-bit word.
// The serial clock runs at half the system clock: each bit is an L cycle (sck=0,
// mosi launched) followed by an H cycle (sck=1, miso captured at its closing edge).
module qspi_rd_master #(
  parameter int unsigned CS_IDLE_CYCLES = 4
) (
  input  logic              qspi_clk,
  input  logic              rst_n,
  qspi_rd_master_if.master  bus
);

  localparam logic [7:0]  CMD_FAST_READ = 8'h0B;
  localparam logic [7:0]  CMD_READ      = 8'h03;

  localparam int unsigned ADDR_W     = 24;
  localparam int unsigned DATA_W     = 32;
  localparam int unsigned SH_W       = 40;
  localparam int unsigned CNT_W      = 6;
  localparam int unsigned CMD_BITS   = 8;
  localparam int unsigned ADDR_BITS  = 24;
  localparam int unsigned DUMMY_BITS = 8;
  localparam int unsigned DATA_BITS  = 32;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CMD,
    S_ADDR,
    S_DUMMY,
    S_DATA,
    S_GAP
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               ph_q, ph_d;
  logic               fast_q, fast_d;
  logic [SH_W-1:0]    sh_q, sh_d;
  logic [DATA_W-1:0]  data_sh_q, data_sh_d;
  logic               csn_q, csn_d;
  logic               sck_q, sck_d;
  logic               mosi_q, mosi_d;
  logic               busy_q, busy_d;
  logic               valid_q, valid_d;
  logic [DATA_W-1:0]  data_q, data_d;

  logic [CNT_W-1:0]   phase_last_c;

  // Index of the final bit in the current serial phase
  always_comb begin
    phase_last_c = CNT_W'(DATA_BITS - 1);
    unique case (state_q)
      S_CMD:   phase_last_c = CNT_W'(CMD_BITS - 1);
      S_ADDR:  phase_last_c = CNT_W'(ADDR_BITS - 1);
      S_DUMMY: phase_last_c = CNT_W'(DUMMY_BITS - 1);
      default: phase_last_c = CNT_W'(DATA_BITS - 1);
    endcase
  end

  // State register and all registered outputs
  always_ff @(posedge qspi_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      ph_q      <= 1'b0;
      fast_q    <= 1'b0;
      sh_q      <= '0;
      data_sh_q <= '0;
      csn_q     <= 1'b1;
      sck_q     <= 1'b0;
      mosi_q    <= 1'b0;
      busy_q    <= 1'b0;
      valid_q   <= 1'b0;
      data_q    <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      ph_q      <= ph_d;
      fast_q    <= fast_d;
      sh_q      <= sh_d;
      data_sh_q <= data_sh_d;
      csn_q     <= csn_d;
      sck_q     <= sck_d;
      mosi_q    <= mosi_d;
      busy_q    <= busy_d;
      valid_q   <= valid_d;
      data_q    <= data_d;
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    ph_d      = ph_q;
    fast_d    = fast_q;
    sh_d      = sh_q;
    data_sh_d = data_sh_q;
    csn_d     = csn_q;
    sck_d     = sck_q;
    mosi_d    = mosi_q;
    busy_d    = busy_q;
    valid_d   = 1'b0;
    data_d    = data_q;

    unique case (state_q)
      S_IDLE: begin
        if (bus.rd_req) begin
          fast_d    = bus.rd_fast;
          sh_d      = {(bus.rd_fast ? CMD_FAST_READ : CMD_READ), bus.rd_addr, 8'h00};
          data_sh_d = '0;
          cnt_d     = '0;
          ph_d      = 1'b0;
          csn_d     = 1'b0;
          sck_d     = 1'b0;
          mosi_d    = bus.rd_fast ? CMD_FAST_READ[7] : CMD_READ[7];
          busy_d    = 1'b1;
          state_d   = S_CMD;
        end
      end

      S_CMD, S_ADDR, S_DUMMY, S_DATA: begin
        if (!ph_q) begin
          // L -> H: raise sck, mosi holds
          ph_d  = 1'b1;
          sck_d = 1'b1;
        end else begin
          // H -> L: bit complete, capture miso, launch the next mosi bit
          ph_d  = 1'b0;
          sck_d = 1'b0;
          sh_d  = {sh_q[SH_W-2:0], 1'b0};
          if (state_q == S_DATA) begin
            data_sh_d = {data_sh_q[DATA_W-2:0], bus.qspi_miso};
          end
          if (cnt_q == phase_last_c) begin
            cnt_d = '0;
            unique case (state_q)
              S_CMD:   state_d = S_ADDR;
              S_ADDR:  state_d = fast_q ? S_DUMMY : S_DATA;
              S_DUMMY: state_d = S_DATA;
              default: begin
                state_d = S_GAP;
                csn_d   = 1'b1;
                valid_d = 1'b1;
                data_d  = data_sh_d;
              end
            endcase
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
          mosi_d = ((state_d == S_CMD) || (state_d == S_ADDR)) ? sh_d[SH_W-1] : 1'b0;
        end
      end

      S_GAP: begin
        // Hold csn high for the idle gap before accepting another request
        if (cnt_q == CNT_W'(CS_IDLE_CYCLES - 1)) begin
          cnt_d   = '0;
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign bus.qspi_csn   = csn_q;
  assign bus.qspi_sck   = sck_q;
  assign bus.qspi_mosi  = mosi_q;
  assign bus.qspi_wpn   = 1'b1;
  assign bus.qspi_holdn = 1'b1;
  assign bus.rd_busy    = busy_q;
  assign bus.rd_valid   = valid_q;
  assign bus.rd_data    = data_q;

endmodule

// File: tb/tb_qspi_rd_master.sv
// Directed bench for qspi_rd_master with a behavioural single-lane flash responder.
module tb_qspi_rd_master;

  localparam int unsigned CS_IDLE = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  qspi_rd_master_if bus();

  qspi_rd_master #(.CS_IDLE_CYCLES(CS_IDLE)) dut (
    .qspi_clk (clk),
    .rst_n    (rst_n),
    .bus      (bus)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check(input string tag, input logic [71:0] got, input logic [71:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Flash responder / bus monitor, evaluated mid-cycle
  logic [31:0] pattern   = '0;
  logic [71:0] mosi_log  = '0;
  logic [71:0] done_log  = '0;
  logic [7:0]  op_seen   = '0;
  logic        csn_prev  = 1'b1;
  logic        mosi_prev = 1'b0;
  logic        mosi_bad  = 1'b0;
  logic        done_bad  = 1'b0;
  logic        miso_drv  = 1'b0;
  int          pulse_cnt = 0;
  int          done_pulses = 0;
  int          txn_cnt   = 0;
  int          valid_cnt = 0;
  int          hi_run    = 0;
  int          last_gap  = 0;
  int          dstart    = 32;

  assign bus.qspi_miso = miso_drv;

  always @(negedge clk) begin
    if (bus.rd_valid) valid_cnt++;
    if (bus.qspi_csn) begin
      if (!csn_prev) begin
        done_log    = mosi_log;
        done_pulses = pulse_cnt;
        done_bad    = mosi_bad;
      end
      hi_run++;
      miso_drv = 1'b0;
    end else begin
      if (csn_prev) begin
        txn_cnt++;
        last_gap  = hi_run;
        hi_run    = 0;
        pulse_cnt = 0;
        mosi_log  = '0;
        mosi_bad  = 1'b0;
        op_seen   = '0;
      end
      if (bus.qspi_sck) begin
        if (bus.qspi_mosi !== mosi_prev) mosi_bad = 1'b1;
        mosi_log = {mosi_log[70:0], bus.qspi_mosi};
        dstart   = (op_seen == 8'h0B) ? 40 : 32;
        if (pulse_cnt >= dstart && pulse_cnt < dstart + 32)
          miso_drv = pattern[31 - (pulse_cnt - dstart)];
        else
          miso_drv = 1'b0;
        pulse_cnt++;
        if (pulse_cnt == 8) op_seen = mosi_log[7:0];
      end else begin
        mosi_prev = bus.qspi_mosi;
      end
    end
    csn_prev = bus.qspi_csn;
  end

  logic [31:0] last_data = '0;

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_idle();
    for (int k = 0; k < 300 && bus.rd_busy; k++) step();
    if (bus.rd_busy) check("idle_timeout", 1, 0);
  endtask

  task automatic do_read(input logic fast, input logic [23:0] addr, input logic [31:0] pat);
    int t0;
    int n2;
    int vc0;
    bit got;
    logic [71:0] exp_log;
    n2      = fast ? 144 : 128;
    exp_log = fast ? {8'h0B, addr, 8'h00, 32'h0} : {8'h00, 8'h03, addr, 32'h0};
    wait_idle();
    vc0         = valid_cnt;
    pattern     = pat;
    t0          = cyc;
    bus.rd_req  = 1'b1;
    bus.rd_fast = fast;
    bus.rd_addr = addr;
    step();
    bus.rd_req  = 1'b0;
    check("busy_after_req", bus.rd_busy, 1);
    got = 1'b0;
    for (int k = 0; k < 400 && !got; k++) begin
      if (bus.rd_valid) got = 1'b1;
      else begin
        if (cyc - t0 == 20) check("data_hold", bus.rd_data, last_data);
        step();
      end
    end
    check("valid_cycle", cyc - t0, n2 + 1);
    check("rd_data", bus.rd_data, pat);
    check("csn_at_valid", bus.qspi_csn, 1);
    step();
    check("valid_one_cycle", bus.rd_valid, 0);
    check("data_held", bus.rd_data, pat);
    repeat (5) @(posedge clk);
    #2;
    check("mosi_bits", done_log, exp_log);
    check("sck_pulses", done_pulses, n2 / 2);
    check("mosi_only_on_low", done_bad, 0);
    check("valid_count", valid_cnt - vc0, 1);
    last_data = pat;
  endtask

  initial begin
    int t0;
    int rel;
    int base;
    int vc0;
    bit got;

    bus.rd_req  = 1'b0;
    bus.rd_fast = 1'b0;
    bus.rd_addr = '0;

    // Reset state
    repeat (3) step();
    check("rst_csn", bus.qspi_csn, 1);
    check("rst_sck", bus.qspi_sck, 0);
    check("rst_mosi", bus.qspi_mosi, 0);
    check("rst_busy", bus.rd_busy, 0);
    check("rst_valid", bus.rd_valid, 0);
    check("rst_data", bus.rd_data, 0);
    check("wpn", bus.qspi_wpn, 1);
    check("holdn", bus.qspi_holdn, 1);
    rst_n = 1'b1;
    repeat (2) step();
    check("idle_csn", bus.qspi_csn, 1);

    // Fast and normal reads
    do_read(1'b1, 24'h123456, 32'hA5C30F96);
    do_read(1'b0, 24'hFFFFF0, 32'h0000FFFF);

    // Requests while busy are dropped; the first legal slot is accepted
    wait_idle();
    base        = txn_cnt;
    vc0         = valid_cnt;
    pattern     = 32'h12345678;
    t0          = cyc;
    bus.rd_req  = 1'b1;
    bus.rd_fast = 1'b0;
    bus.rd_addr = 24'hABCDEF;
    for (int k = 0; k < 136; k++) begin
      step();
      rel = cyc - t0;
      bus.rd_req = (rel == 10 || rel == 130 || rel == 133);
      if (rel == 10) begin
        bus.rd_fast = 1'b1;
        bus.rd_addr = 24'h555555;
      end
      if (rel == 129) begin
        check("busy_valid", bus.rd_valid, 1);
        check("busy_data", bus.rd_data, 32'h12345678);
        pattern = 32'hDEADBEEF;
      end
      if (rel == 130) check("busy_in_gap", bus.rd_busy, 1);
      if (rel == 133) begin
        check("busy_gap_end", bus.rd_busy, 0);
        check("busy_one_txn", txn_cnt - base, 1);
        check("busy_mosi_bits", done_log, {8'h00, 8'h03, 24'hABCDEF, 32'h0});
        check("busy_sck_pulses", done_pulses, 64);
        bus.rd_fast = 1'b1;
        bus.rd_addr = 24'h000001;
      end
      if (rel == 134) begin
        check("next_accept_busy", bus.rd_busy, 1);
        check("next_accept_csn", bus.qspi_csn, 0);
      end
      if (rel == 135) begin
        check("csn_gap", last_gap, 5);
        check("two_txn", txn_cnt - base, 2);
      end
    end
    bus.rd_req = 1'b0;
    got = 1'b0;
    for (int k = 0; k < 400 && !got; k++) begin
      if (bus.rd_valid) got = 1'b1;
      else step();
    end
    check("second_valid_cycle", cyc - (t0 + 133), 145);
    check("second_data", bus.rd_data, 32'hDEADBEEF);
    repeat (6) step();
    check("second_mosi_bits", done_log, {8'h0B, 24'h000001, 8'h00, 32'h0});
    check("busy_valid_count", valid_cnt - vc0, 2);
    last_data = 32'hDEADBEEF;

    // Asynchronous reset in the middle of the address phase
    wait_idle();
    vc0         = valid_cnt;
    pattern     = 32'hA5C30F96;
    bus.rd_req  = 1'b1;
    bus.rd_fast = 1'b1;
    bus.rd_addr = 24'h123456;
    step();
    bus.rd_req  = 1'b0;
    repeat (29) @(posedge clk);
    #2;
    check("mid_addr_csn", bus.qspi_csn, 0);
    rst_n = 1'b0;
    #1;
    check("arst_csn", bus.qspi_csn, 1);
    check("arst_sck", bus.qspi_sck, 0);
    check("arst_mosi", bus.qspi_mosi, 0);
    check("arst_busy", bus.rd_busy, 0);
    check("arst_data", bus.rd_data, 0);
    repeat (3) step();
    rst_n = 1'b1;
    repeat (200) step();
    check("arst_no_valid", valid_cnt - vc0, 0);
    last_data = '0;
    do_read(1'b1, 24'h123456, 32'hA5C30F96);

    // Back-to-back with alternating mode
    do_read(1'b1, 24'h0F0F0F, 32'h80000001);
    do_read(1'b0, 24'h00A5A5, 32'h7FFFFFFE);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  // Global watchdog
  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
